seq_div: RTL and testbench

- Iterative restoring divider for the calculator datapath: N-bit unsigned dividend / N-bit unsigned divisor -> N-bit quotient and N-bit remainder.
- Consumes the sub_div subtractor as its trial-subtract stage, one quotient bit per clock.
- Sits between the operand/opcode decode and the result mux.
- Uses a start/busy/done handshake so the control FSM can launch a divide and wait for the result.

---
 rtl/div_defs_pkg.sv | 14 +
 rtl/sub_div.sv | 13 +
 rtl/seq_div.sv | 107 ++++++++++
 tb/tb_seq_div.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_defs_pkg.sv
// Shared definitions for the iterative divider: FSM encodings and the
// fill value used to build the divide-by-zero quotient.
package div_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   // Replicated to the operand width: a divide by zero returns all-ones.
   localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/sub_div.sv
// Trial-subtract stage of the divider: plain W-bit modulo subtraction.
// The MSB of the result doubles as the borrow when operands are zero-extended.
module sub_div #(
   parameter int W = 9
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_diff
);

   assign o_diff = i_a - i_b;

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider, one quotient bit per clock, with a
// start/busy/done handshake toward the calculator control FSM.
module seq_div
   import div_defs::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N + 1);

   div_state_t  r_state;
   // The restored partial remainder is always below the divisor, so its
   // (N+1)th bit is zero between iterations and is not stored.
   logic [N-1:0]  r_r;
   logic [N-1:0]  r_q;
   logic [N-1:0]  r_d;
   logic [CW-1:0] r_cnt;

   logic [N:0]    w_shift;
   logic [N:0]    w_trial;
   logic          w_take;
   logic [N:0]    w_r_next;
   logic [N-1:0]  w_q_next;
   logic          w_last;

   assign w_shift = {r_r, r_q[N-1]};

   sub_div #(.W(N + 1)) u_sub (
      .i_a   (w_shift),
      .i_b   ({1'b0, r_d}),
      .o_diff(w_trial)
   );

   assign w_take   = ~w_trial[N];
   assign w_r_next = w_take ? w_trial : w_shift;
   assign w_q_next = {r_q[N-2:0], w_take};
   assign w_last   = (r_cnt == CW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_r         <= '0;
         r_q         <= '0;
         r_d         <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            // DONE accepts a new start exactly like IDLE for back-to-back ops
            ST_IDLE, ST_DONE: begin
               busy    <= 1'b0;
               r_state <= ST_IDLE;
               if (start) begin
                  if (divisor == '0) begin
                     r_state     <= ST_DONE;
                     done        <= 1'b1;
                     quotient    <= {N{DBZ_Q_FILL}};
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     r_d     <= divisor;
                     r_q     <= dividend;
                     r_r     <= '0;
                     r_cnt   <= CW'(N);
                     r_state <= ST_RUN;
                     busy    <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_r   <= w_r_next[N-1:0];
               r_q   <= w_q_next;
               r_cnt <= r_cnt - CW'(1);
               if (w_last) begin
                  r_state     <= ST_DONE;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  quotient    <= w_q_next;
                  remainder   <= w_r_next[N-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: expectations are queued at launch and a
// negedge monitor checks every done pulse against the head of the queue.
module tb_seq_div;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         z;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   seq_div #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.z));
            chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", int'(busy), 0);
         end
      end
   end

   // now=1: drive start in the current (negedge) slot instead of waiting.
   task automatic launch(input bit now, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit push, input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ez, output int acc);
      exp_t e;
      if (!now) @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk);
      #1;
      acc = cyc;
      start = 1'b0;
      if (push) begin
         e.q = eq;
         e.r = er;
         e.z = ez;
         e.cyc = ez ? acc : acc + N;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(output int nbusy);
      nbusy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) return;
         if (busy) nbusy++;
      end
      chk("done_timeout", 0, 1);
   endtask

   initial begin
      int acc;
      int nb;

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      @(posedge clk);
      #2 rst = 1'b0;

      launch(0, 8'd200, 8'd7, 1, 8'd28, 8'd4, 1'b0, acc);
      wait_done(nb);
      chk("busy_cycles_200_7", nb, N);

      launch(0, 8'd5, 8'd9, 1, 8'd0, 8'd5, 1'b0, acc);
      wait_done(nb);
      launch(0, 8'd255, 8'd1, 1, 8'd255, 8'd0, 1'b0, acc);
      wait_done(nb);
      launch(0, 8'd255, 8'd255, 1, 8'd1, 8'd0, 1'b0, acc);
      wait_done(nb);

      launch(0, 8'd13, 8'd0, 1, 8'd255, 8'd13, 1'b1, acc);
      wait_done(nb);
      chk("busy_cycles_dbz", nb, 0);

      // Second start mid-run must be ignored; operand changes must not leak in.
      launch(0, 8'd100, 8'd3, 1, 8'd33, 8'd1, 1'b0, acc);
      while (cyc < acc + 3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      dividend = 8'd50;
      divisor = 8'd5;
      @(negedge clk);
      start = 1'b0;
      dividend = 8'd77;
      divisor = 8'd0;
      wait_done(nb);
      launch(1, 8'd60, 8'd7, 1, 8'd8, 8'd4, 1'b0, acc);
      wait_done(nb);
      chk("busy_cycles_b2b", nb, N);

      repeat (3) @(negedge clk);
      chk("hold_quotient", int'(quotient), 8);
      chk("hold_remainder", int'(remainder), 4);
      chk("hold_done_low", int'(done), 0);

      launch(0, 8'd200, 8'd7, 0, 8'd0, 8'd0, 1'b0, acc);
      chk("held_after_start_q", int'(quotient), 8);
      chk("busy_after_start", int'(busy), 1);
      while (cyc < acc + 4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_quotient", int'(quotient), 0);
      chk("abort_remainder", int'(remainder), 0);
      chk("abort_dbz", int'(div_by_zero), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      launch(0, 8'd9, 8'd2, 1, 8'd4, 8'd1, 1'b0, acc);
      wait_done(nb);
      chk("busy_cycles_9_2", nb, N);

      repeat (12) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
